// File: rtl/seq_scan_ctrl_pkg.sv
// Shared definitions for the serial pattern scanner.
// Holds the controller state encoding, the pattern/length loaded at reset and the
// default parameter values used by the interface and the top level.
package seq_scan_ctrl_pkg;

  localparam int unsigned MaxPatDefault = 8;
  localparam int unsigned CntWDefault   = 16;

  // Reset pattern 'b101 of length 3; zero-extended to MAX_PAT where used.
  localparam logic [7:0] RstPattern = 8'b0000_0101;
  localparam logic [3:0] RstLen     = 4'd3;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Bus bundle for seq_scan_ctrl.
// Groups the config port (cfg_we/cfg_pattern/cfg_len/cfg_err), the byte input
// handshake (in_valid/in_data/in_last/in_ready) and the result outputs
// (match/match_pos/match_count/busy/done).
// master: the side that drives bytes and config; slave: the scanner.
interface seq_scan_ctrl_if
  import seq_scan_ctrl_pkg::*;
#(
  parameter int unsigned MAX_PAT = MaxPatDefault,
  parameter int unsigned CNT_W   = CntWDefault
);

  logic               cfg_we;
  logic [MAX_PAT-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic               cfg_err;

  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_last;
  logic               in_ready;

  logic               match;
  logic [CNT_W-1:0]   match_pos;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, in_valid, in_data, in_last,
    input  cfg_err, in_ready, match, match_pos, match_count, busy, done
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, in_valid, in_data, in_last,
    output cfg_err, in_ready, match, match_pos, match_count, busy, done
  );

endinterface

// File: rtl/seq_scan_ctrl_bit_serializer.sv
// Byte-to-bit serializer for seq_scan_ctrl.
// Latches an accepted byte and its last flag, then presents its bits MSB first
// via a down-counting bit index. Also produces the input ready and handshake.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_data/in_last  byte input
//   idle, shift         controller is in IDLE / SHIFT
//   in_ready, accept    ready to the source, and ready & valid
//   bit_out             data bit at the current index
//   idx_zero            current bit is the byte's last (bit 0)
//   last                latched in_last of the byte being shifted
module seq_scan_ctrl_bit_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       idle,
  input  logic       shift,
  output logic       in_ready,
  output logic       accept,
  output logic       bit_out,
  output logic       idx_zero,
  output logic       last
);

  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic [2:0] bit_idx_q, bit_idx_d;

  assign idx_zero = (bit_idx_q == 3'd0);
  // Next byte can only be taken in its predecessor's bit-0 cycle, and never
  // after the frame's final byte.
  assign in_ready = rst_n && (idle || (shift && idx_zero && !last_q));
  assign accept   = in_valid && in_ready;
  assign bit_out  = data_q[bit_idx_q];
  assign last     = last_q;

  always_comb begin
    data_d    = data_q;
    last_d    = last_q;
    bit_idx_d = bit_idx_q;
    if (accept) begin
      data_d    = in_data;
      last_d    = in_last;
      bit_idx_d = 3'd7;
    end else if (shift && !idx_zero) begin
      bit_idx_d = bit_idx_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      last_q    <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      data_q    <= data_d;
      last_q    <= last_d;
      bit_idx_q <= bit_idx_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serial pattern scanner over a byte stream.
// Bytes are serialized MSB first into a sliding window that is compared with a
// programmable 1..MAX_PAT bit pattern (overlapping matches allowed). Every match
// is reported with its frame bit index; matches per frame are counted
// (saturating) and done pulses at frame end.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   bus         seq_scan_ctrl_if slave: config, byte input, results
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int unsigned MAX_PAT = MaxPatDefault,
  parameter int unsigned CNT_W   = CntWDefault
) (
  input logic            clk,
  input logic            rst_n,
  seq_scan_ctrl_if.slave bus
);

  localparam int unsigned FillW = $clog2(MAX_PAT + 1);

  state_e             state_q, state_d;
  logic               frame_open_q, frame_open_d;
  logic [MAX_PAT-1:0] window_q, window_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   match_pos_q, match_pos_d;
  logic [MAX_PAT-1:0] pat_q;
  logic [3:0]         len_q;
  logic               cfg_err_q;

  logic               ser_accept, ser_bit, ser_idx_zero, ser_last, ser_ready;
  logic [MAX_PAT-1:0] win_shift, pat_mask;
  logic [FillW-1:0]   fill_inc;
  logic               hit, cfg_ok;

  seq_scan_ctrl_bit_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data),
    .in_last  (bus.in_last),
    .idle     (state_q == StIdle),
    .shift    (state_q == StShift),
    .in_ready (ser_ready),
    .accept   (ser_accept),
    .bit_out  (ser_bit),
    .idx_zero (ser_idx_zero),
    .last     (ser_last)
  );

  // Only the low len bits of window and pattern take part in the compare.
  always_comb begin
    pat_mask = '0;
    for (int unsigned i = 0; i < MAX_PAT; i++) begin
      pat_mask[i] = (i < 32'(len_q));
    end
  end

  assign win_shift = {window_q[MAX_PAT-2:0], ser_bit};
  assign fill_inc  = (fill_q == FillW'(MAX_PAT)) ? fill_q : fill_q + FillW'(1);
  // Compare against the window including this cycle's bit.
  assign hit = (32'(fill_inc) >= 32'(len_q)) &&
               ((win_shift & pat_mask) == (pat_q & pat_mask));

  assign cfg_ok = bus.cfg_we && (state_q == StIdle) && !frame_open_q &&
                  (bus.cfg_len != 4'd0) && (32'(bus.cfg_len) <= MAX_PAT);

  always_comb begin
    state_d       = state_q;
    frame_open_d  = frame_open_q;
    window_d      = window_q;
    fill_d        = fill_q;
    bit_cnt_d     = bit_cnt_q;
    match_count_d = match_count_q;
    match_d       = 1'b0;
    match_pos_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (ser_accept) begin
          state_d = StShift;
          // First byte of a frame; a resumed frame keeps its window and counters.
          if (!frame_open_q) begin
            frame_open_d  = 1'b1;
            window_d      = '0;
            fill_d        = '0;
            bit_cnt_d     = '0;
            match_count_d = '0;
          end
        end
      end
      StShift: begin
        window_d  = win_shift;
        fill_d    = fill_inc;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (hit) begin
          match_d     = 1'b1;
          match_pos_d = bit_cnt_q;
          if (match_count_q != {CNT_W{1'b1}}) begin
            match_count_d = match_count_q + CNT_W'(1);
          end
        end
        if (ser_idx_zero) begin
          if (ser_last) begin
            state_d = StDone;
          end else if (!ser_accept) begin
            state_d = StIdle;
          end
        end
      end
      StDone: begin
        state_d      = StIdle;
        frame_open_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      frame_open_q  <= 1'b0;
      window_q      <= '0;
      fill_q        <= '0;
      bit_cnt_q     <= '0;
      match_count_q <= '0;
      match_q       <= 1'b0;
      match_pos_q   <= '0;
      pat_q         <= MAX_PAT'(RstPattern);
      len_q         <= RstLen;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_open_q  <= frame_open_d;
      window_q      <= window_d;
      fill_q        <= fill_d;
      bit_cnt_q     <= bit_cnt_d;
      match_count_q <= match_count_d;
      match_q       <= match_d;
      match_pos_q   <= match_pos_d;
      if (cfg_ok) begin
        pat_q <= bus.cfg_pattern;
        len_q <= bus.cfg_len;
      end
      cfg_err_q <= bus.cfg_we && !cfg_ok;
    end
  end

  assign bus.in_ready    = ser_ready;
  assign bus.match       = match_q;
  assign bus.match_pos   = match_pos_q;
  assign bus.match_count = match_count_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.busy        = rst_n && (state_q == StShift);
  assign bus.done        = rst_n && (state_q == StDone);

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl. Two instances share one stimulus stream:
// dut_a with CNT_W=16 and dut_b with CNT_W=4 (used for counter saturation).
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [3:0] cfg_len = 4'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int a_pos[$];
  int a_cyc[$];
  int a_done = 0;
  int a_done_cyc = -1;
  int b_match = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_scan_ctrl_if #(.MAX_PAT(8), .CNT_W(16)) bus_a ();
  seq_scan_ctrl_if #(.MAX_PAT(8), .CNT_W(4))  bus_b ();

  assign bus_a.cfg_we      = cfg_we;
  assign bus_a.cfg_pattern = cfg_pattern;
  assign bus_a.cfg_len     = cfg_len;
  assign bus_a.in_valid    = in_valid;
  assign bus_a.in_data     = in_data;
  assign bus_a.in_last     = in_last;
  assign bus_b.cfg_we      = cfg_we;
  assign bus_b.cfg_pattern = cfg_pattern;
  assign bus_b.cfg_len     = cfg_len;
  assign bus_b.in_valid    = in_valid;
  assign bus_b.in_data     = in_data;
  assign bus_b.in_last     = in_last;

  seq_scan_ctrl #(.MAX_PAT(8), .CNT_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  seq_scan_ctrl #(.MAX_PAT(8), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // Event log, sampled on the falling edge; cyc identifies the clock cycle.
  always @(negedge clk) begin
    if (bus_a.match === 1'b1) begin
      a_pos.push_back(int'(bus_a.match_pos));
      a_cyc.push_back(cyc);
    end
    if (bus_a.done === 1'b1) begin
      a_done     <= a_done + 1;
      a_done_cyc <= cyc;
    end
    if (bus_b.match === 1'b1) b_match <= b_match + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    tick();
    cfg_we      = 1'b0;
  endtask

  // Offers a byte, returns the handshake cycle; returns one cycle after it.
  task automatic send(input logic [7:0] d, input logic l, output int t);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (bus_a.in_ready !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    chk("ready_wait", 32'(guard < 40), 1);
    t = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int t, t1, t2, base, dbase, bbase;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", bus_a.in_ready, 0);
    chk("rst_match", bus_a.match, 0);
    chk("rst_match_pos", bus_a.match_pos, 0);
    chk("rst_count", bus_a.match_count, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_cfg_err", bus_a.cfg_err, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", bus_a.in_ready, 1);
    tick();

    // Single byte 0xA5, default pattern 101
    base  = a_pos.size();
    dbase = a_done;
    send(8'hA5, 1'b1, t);
    chk("a5_busy", bus_a.busy, 1);
    chk("a5_ready_shift", bus_a.in_ready, 0);
    repeat (12) tick();
    chk("a5_nmatch", a_pos.size() - base, 2);
    chk("a5_pos0", a_pos[base], 2);
    chk("a5_cyc0", a_cyc[base], t + 4);
    chk("a5_pos1", a_pos[base+1], 7);
    chk("a5_cyc1", a_cyc[base+1], t + 9);
    chk("a5_done", a_done - dbase, 1);
    chk("a5_done_cyc", a_done_cyc, t + 9);
    chk("a5_count", bus_a.match_count, 2);
    chk("a5_busy_end", bus_a.busy, 0);

    // Pattern 1001, cross-byte overlap, gapless
    cfg_write(8'h09, 4'd4);
    chk("cfg_ok_err", bus_a.cfg_err, 0);
    base  = a_pos.size();
    dbase = a_done;
    send(8'h01, 1'b0, t1);
    send(8'h20, 1'b1, t2);
    chk("x_gapless", t2, t1 + 8);
    repeat (12) tick();
    chk("x_nmatch", a_pos.size() - base, 1);
    chk("x_pos", a_pos[base], 10);
    chk("x_cyc", a_cyc[base], t1 + 12);
    chk("x_count", bus_a.match_count, 1);
    chk("x_done_cyc", a_done_cyc, t2 + 9);
    chk("x_done", a_done - dbase, 1);

    // Same bytes with an idle gap; rejected config write in the gap
    base  = a_pos.size();
    dbase = a_done;
    send(8'h01, 1'b0, t1);
    repeat (12) tick();
    chk("gap_busy", bus_a.busy, 0);
    chk("gap_ready", bus_a.in_ready, 1);
    chk("gap_count", bus_a.match_count, 0);
    chk("gap_nodone", a_done - dbase, 0);
    cfg_write(8'hFF, 4'd1);
    chk("gap_cfg_err", bus_a.cfg_err, 1);
    send(8'h20, 1'b1, t2);
    repeat (12) tick();
    chk("gap_nmatch", a_pos.size() - base, 1);
    chk("gap_pos", a_pos[base], 10);
    chk("gap_cyc", a_cyc[base], t2 + 4);
    chk("gap_count_end", bus_a.match_count, 1);
    chk("gap_done", a_done - dbase, 1);

    // Config rejects
    cfg_write(8'hFF, 4'd0);
    chk("rej_len0", bus_a.cfg_err, 1);
    tick();
    chk("rej_pulse", bus_a.cfg_err, 0);
    cfg_write(8'hFF, 4'd9);
    chk("rej_len9", bus_a.cfg_err, 1);
    send(8'h00, 1'b1, t);
    cfg_write(8'h01, 4'd1);
    chk("rej_shift", bus_a.cfg_err, 1);
    chk("rej_shift_busy", bus_a.busy, 1);
    repeat (12) tick();
    chk("rej_zero_count", bus_a.match_count, 0);
    base = a_pos.size();
    send(8'h99, 1'b1, t);
    repeat (12) tick();
    chk("rej_nmatch", a_pos.size() - base, 2);
    chk("rej_pos0", a_pos[base], 3);
    chk("rej_pos1", a_pos[base+1], 7);
    chk("rej_count", bus_a.match_count, 2);

    // Saturation: pattern 1, len 1, two 0xFF bytes
    cfg_write(8'h01, 4'd1);
    chk("sat_cfg_err", bus_a.cfg_err, 0);
    base  = a_pos.size();
    bbase = b_match;
    send(8'hFF, 1'b0, t1);
    send(8'hFF, 1'b1, t2);
    repeat (12) tick();
    chk("sat_b_pulses", b_match - bbase, 16);
    chk("sat_b_count", bus_b.match_count, 15);
    chk("sat_a_nmatch", a_pos.size() - base, 16);
    chk("sat_a_count", bus_a.match_count, 16);
    chk("sat_a_lastpos", a_pos[a_pos.size()-1], 15);

    // Reset mid-frame
    send(8'hFF, 1'b1, t);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_busy", bus_a.busy, 0);
    chk("mrst_match", bus_a.match, 0);
    chk("mrst_count", bus_a.match_count, 0);
    chk("mrst_done", bus_a.done, 0);
    chk("mrst_ready", bus_a.in_ready, 0);
    chk("mrst_b_count", bus_b.match_count, 0);
    base  = a_pos.size();
    dbase = a_done;
    rst_n = 1'b1;
    repeat (12) tick();
    chk("mrst_nomatch", a_pos.size() - base, 0);
    chk("mrst_nodone", a_done - dbase, 0);
    send(8'hA5, 1'b1, t);
    repeat (12) tick();
    chk("post_nmatch", a_pos.size() - base, 2);
    chk("post_pos0", a_pos[base], 2);
    chk("post_pos1", a_pos[base+1], 7);
    chk("post_count", bus_a.match_count, 2);
    chk("post_done", a_done - dbase, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Controller that runs serial pattern detection over a byte stream. It accepts bytes on a valid/ready interface and serializes them MSB-first, one bit per clock. Each bit goes into a sliding window that is compared against a programmable 1–8-bit pattern; overlapping matches are allowed. The block reports every match with its bit position, keeps a per-frame match count, and pulses `done` at frame end. It sits between the byte-oriented crypto datapath and the bit-level detectors, and generalises the fixed-pattern FSM detector.

## Interface
Parameters:
- `MAX_PAT`, 8: maximum pattern length in bits.
- `CNT_W`, 16: width of the bit-position and match counters.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_pattern`  in  MAX_PAT  pattern; bit `len-1` is the first bit expected in time.
- `cfg_len`  in  4  pattern length, legal range 1..MAX_PAT.
- `cfg_err`  out  1  one-cycle pulse when a config write is rejected.
- `in_valid`  in  1  byte available.
- `in_data`  in  8  byte, serialized MSB first.
- `in_last`  in  1  byte is the final byte of its frame.
- `in_ready`  out  1  block accepts a byte this cycle.
- `match`  out  1  one-cycle pulse per match.
- `match_pos`  out  CNT_W  frame bit index of the match's last bit; valid while `match` is high.
- `match_count`  out  CNT_W  matches in the current or most recent frame; saturating.
- `busy`  out  1  high in SHIFT.
- `done`  out  1  one-cycle frame-complete pulse.

## Operation
- **States:** IDLE, SHIFT, DONE. Flag `frame_open` marks a frame in progress.
- **IDLE:**
  - `in_ready`=1.
  - On handshake: latch `in_data` and `in_last`, set `bit_idx`=7, go to SHIFT.
  - If `frame_open`=0 at that handshake: clear window, bit counter, fill count and `match_count`, then set `frame_open`=1.
- **SHIFT, each cycle:**
  - `window <= {window[MAX_PAT-2:0], data[bit_idx]}`.
  - Fill count increments, saturating at MAX_PAT.
  - Bit counter increments, wrapping modulo 2^CNT_W.
  - A match is the condition: fill ≥ len and `window'[len-1:0] == pattern[len-1:0]`, where `window'` is the updated window.
- **SHIFT at `bit_idx`=0:**
  - `in_ready`=1 only if the latched `last`=0.
  - If last=1: go to DONE.
  - Else if `in_valid`: latch the next byte, `bit_idx`=7, stay in SHIFT (gapless).
  - Else: go to IDLE with `frame_open`=1; window and counters are retained.
- **SHIFT at `bit_idx`≠0:** `in_ready`=0; `bit_idx` decrements.
- **DONE:** `done`=1 for one cycle, clear `frame_open`, go to IDLE. `match_count` holds until the first byte of the next frame is accepted.
- **Config writes:**
  - Accepted only in IDLE with `frame_open`=0 and 1 ≤ `cfg_len` ≤ MAX_PAT.
  - Otherwise `cfg_err` pulses on the next cycle and config is unchanged.
  - A rejected strobe never disturbs scanning.
- **Match counter:** saturates at 2^CNT_W−1. `match` pulses continue after saturation.
- **Reset state:**
  - State IDLE, `frame_open`=0, window 0.
  - Pattern = 3'b101 zero-extended, len=3.
  - Outputs `match`, `match_pos`, `match_count`, `busy`, `done`, `cfg_err` = 0; `in_ready`=0 while `rst_n`=0.
  - Reset mid-frame abandons the frame: no `done`, no further `match`.

## Timing
- Byte accepted at cycle T → its 8 bits are shifted at T+1..T+8.
- `match` and `match_pos` are registered: they assert one cycle after the shift cycle of the completing bit.
- `done` asserts at T+9 for the final byte, the same cycle as a match on that byte's last bit.
- Sustained throughput is one byte per 8 cycles when `in_valid` is held high. The next byte's handshake occurs in that byte's bit-0 cycle.
- `cfg_err` has one-cycle latency after `cfg_we`.

## Structure
- Shared package holds:
  - State encoding: IDLE, SHIFT, DONE.
  - Reset constants: pattern 'b101, length 3.
  - `MAX_PAT` default.
- One sub-module, `bit_serializer`: byte latch, `bit_idx` down-counter, ready/last logic.
- Window, compare and counters stay in the top level.

## Test plan
- **Single byte, default pattern:** 0xA5 with last=1 at T → `match` at T+4 (pos 2) and T+9 (pos 7); `done` at T+9; `match_count`=2.
- **Cross-byte overlap:** pattern 4'b1001 len=4; bytes 0x01 then 0x20 (last) back-to-back → exactly one match, pos 10, count 1; no idle cycle between the bytes.
- **Gap mid-frame:** same as above with `in_valid` low for 5 cycles between the bytes → same pos and count; window retained.
- **Config rejects:** `cfg_len`=0 → `cfg_err`; `cfg_len`=9 → `cfg_err`; `cfg_we` during SHIFT → `cfg_err`. Pattern and length unchanged in all three cases.
- **Saturation:** CNT_W=4, pattern 1'b1 len=1, bytes 0xFF, 0xFF (last) → 16 `match` pulses; `match_count` stops at 15.
- **Reset mid-frame:** `rst_n` low for one cycle during SHIFT → next cycle IDLE, all outputs 0, no `done`, default pattern restored. A following frame scans correctly.
